// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus sequencer and the bus multiplexer top level:
// state encoding, opcode values, bus select codes and ALU operation codes.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OPC_AND = 3'd0,
    OPC_ADD = 3'd1,
    OPC_LDA = 3'd2,
    OPC_STA = 3'd3,
    OPC_BUN = 3'd4,
    OPC_HLT = 3'd5,
    OPC_NOP = 3'd6
  } op_class_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_BUN = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_AR   = 3'b001;
  localparam logic [2:0] BUS_PC   = 3'b010;
  localparam logic [2:0] BUS_DR   = 3'b011;
  localparam logic [2:0] BUS_AC   = 3'b100;
  localparam logic [2:0] BUS_IR   = 3'b101;
  localparam logic [2:0] BUS_RAM  = 3'b111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;

  // Any opcode without a defined meaning behaves as a no-op.
  function automatic op_class_t classify(input logic [3:0] op);
    case (op)
      OP_AND:  return OPC_AND;
      OP_ADD:  return OPC_ADD;
      OP_LDA:  return OPC_LDA;
      OP_STA:  return OPC_STA;
      OP_BUN:  return OPC_BUN;
      OP_HLT:  return OPC_HLT;
      default: return OPC_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode class) into bus select, register
// strobes and ALU operation for one cycle of the instruction sequence.
module ctrl_decode
  import bus_ctrl_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] op_class,
  output logic [2:0] bus_sel,
  output logic       ld_ar,
  output logic       ld_pc,
  output logic       inr_pc,
  output logic       ld_dr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       mem_we,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       halted
);

  always_comb begin
    bus_sel = BUS_NONE;
    ld_ar   = 1'b0;
    ld_pc   = 1'b0;
    inr_pc  = 1'b0;
    ld_dr   = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    mem_we  = 1'b0;
    alu_op  = ALU_PASS;
    busy    = (state != ST_IDLE) && (state != ST_HALT);
    halted  = (state == ST_HALT);
    case (state)
      ST_T0: begin
        bus_sel = BUS_PC;
        ld_ar   = 1'b1;
      end
      ST_T1: begin
        bus_sel = BUS_RAM;
        ld_ir   = 1'b1;
        inr_pc  = 1'b1;
      end
      ST_T2: begin
        bus_sel = BUS_IR;
        ld_ar   = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          OPC_AND, OPC_ADD, OPC_LDA: begin
            bus_sel = BUS_RAM;
            ld_dr   = 1'b1;
          end
          OPC_STA: begin
            bus_sel = BUS_AC;
            mem_we  = 1'b1;
          end
          OPC_BUN: begin
            bus_sel = BUS_AR;
            ld_pc   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        ld_ac = 1'b1;
        case (op_class)
          OPC_AND: alu_op = ALU_AND;
          OPC_ADD: alu_op = ALU_ADD;
          default: alu_op = ALU_PASS;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_seq_ctrl.sv
// Instruction sequencer for a simple accumulator machine: steps fetch/decode/
// execute phases and drives the bus select and register strobes.
module bus_seq_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  output logic [2:0]        bus_sel,
  output logic              ld_ar,
  output logic              ld_pc,
  output logic              inr_pc,
  output logic              ld_dr,
  output logic              ld_ir,
  output logic              ld_ac,
  output logic              mem_we,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              halted
);

  localparam int OP_W = DATA_W - ADDR_W;

  state_t          state_reg, state_next;
  logic [OP_W-1:0] opcode_reg, opcode_next;
  op_class_t       op_cur, op_next;

  logic [2:0] bus_sel_next;
  logic       ld_ar_next, ld_pc_next, inr_pc_next, ld_dr_next;
  logic       ld_ir_next, ld_ac_next, mem_we_next;
  logic [1:0] alu_op_next;
  logic       busy_next, halted_next;

  // The address field is consumed by the datapath, not the sequencer.
  logic unused_addr;
  assign unused_addr = ^ir[ADDR_W-1:0];

  always_comb begin
    opcode_next = (state_reg == ST_T2) ? ir[DATA_W-1:ADDR_W] : opcode_reg;
    op_cur      = classify(4'(opcode_reg));
    op_next     = classify(4'(opcode_next));
    state_next  = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = start ? ST_T0 : ST_IDLE;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        case (op_cur)
          OPC_AND, OPC_ADD, OPC_LDA: state_next = ST_T4;
          OPC_HLT:                   state_next = ST_HALT;
          default:                   state_next = ST_IDLE;
        endcase
      end
      ST_T4:   state_next = ST_IDLE;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decoding the next state lets the outputs be registered yet still line up
  // with the state they belong to.
  ctrl_decode u_decode (
    .state    (state_next),
    .op_class (op_next),
    .bus_sel  (bus_sel_next),
    .ld_ar    (ld_ar_next),
    .ld_pc    (ld_pc_next),
    .inr_pc   (inr_pc_next),
    .ld_dr    (ld_dr_next),
    .ld_ir    (ld_ir_next),
    .ld_ac    (ld_ac_next),
    .mem_we   (mem_we_next),
    .alu_op   (alu_op_next),
    .busy     (busy_next),
    .halted   (halted_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= '0;
      bus_sel    <= BUS_NONE;
      ld_ar      <= 1'b0;
      ld_pc      <= 1'b0;
      inr_pc     <= 1'b0;
      ld_dr      <= 1'b0;
      ld_ir      <= 1'b0;
      ld_ac      <= 1'b0;
      mem_we     <= 1'b0;
      alu_op     <= ALU_PASS;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      bus_sel    <= bus_sel_next;
      ld_ar      <= ld_ar_next;
      ld_pc      <= ld_pc_next;
      inr_pc     <= inr_pc_next;
      ld_dr      <= ld_dr_next;
      ld_ir      <= ld_ir_next;
      ld_ac      <= ld_ac_next;
      mem_we     <= mem_we_next;
      alu_op     <= alu_op_next;
      busy       <= busy_next;
      halted     <= halted_next;
    end
  end

endmodule
